// File: rtl/fish_bbox_tracker.sv
// Per-frame extent tracker for fish-mask pixels inside a fixed ROI.
// At each frame end it commits the box corner, the pixel count and a valid flag that survives short dropouts.
module fish_bbox_tracker #(
    parameter logic [10:0] X1         = 11'd181,
    parameter logic [10:0] X2         = 11'd331,
    parameter logic [9:0]  Y1         = 10'd121,
    parameter logic [9:0]  Y2         = 10'd220,
    parameter logic [15:0] MIN_PIX    = 16'd16,
    parameter logic [3:0]  MISS_LIMIT = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    input  logic        mask,
    input  logic        frame_end,
    output logic [10:0] T_x,
    output logic [9:0]  T_y,
    output logic        box_valid,
    output logic [15:0] pix_count,
    output logic        update
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 16;
    localparam int unsigned MW = 4;

    typedef enum logic {SYNC, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
    logic [XW-1:0]   acc_x_q, acc_x_d;
    logic [YW-1:0]   acc_y_q, acc_y_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [XW-1:0]   tx_q, tx_d;
    logic [YW-1:0]   ty_q, ty_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            upd_q, upd_d;

    logic            hit;
    logic [CW-1:0]   m_cnt;
    logic [XW-1:0]   m_x;
    logic [YW-1:0]   m_y;
    logic [MW:0]     miss_inc;

    // Current pixel merged into the running frame accumulators
    always_comb begin
        hit   = en & mask & (pix_x >= X1) & (pix_x <= X2) & (pix_y >= Y1) & (pix_y <= Y2);
        m_cnt = acc_cnt_q;
        m_x   = acc_x_q;
        m_y   = acc_y_q;
        if (hit) begin
            if (acc_cnt_q != {CW{1'b1}}) begin
                m_cnt = acc_cnt_q + CW'(1);
            end
            if (pix_x > acc_x_q) begin
                m_x = pix_x;
            end
            if (pix_y > acc_y_q) begin
                m_y = pix_y;
            end
        end
        miss_inc = {1'b0, miss_q} + (MW+1)'(1);
    end

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        miss_d    = miss_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        upd_d     = 1'b0;
        case (state_q)
            SYNC: begin
                if (frame_end) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                    acc_x_d   = X1;
                    acc_y_d   = Y1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    upd_d     = 1'b1;
                    cnt_d     = m_cnt;
                    acc_cnt_d = '0;
                    acc_x_d   = X1;
                    acc_y_d   = Y1;
                    if (m_cnt >= MIN_PIX) begin
                        tx_d    = m_x;
                        ty_d    = m_y;
                        valid_d = 1'b1;
                        miss_d  = '0;
                    end else if (miss_inc < {1'b0, MISS_LIMIT}) begin
                        miss_d = miss_inc[MW-1:0];
                    end else begin
                        // Persistent miss: collapse box to the ROI origin
                        tx_d    = X1;
                        ty_d    = Y1;
                        valid_d = 1'b0;
                        miss_d  = MISS_LIMIT;
                    end
                end else begin
                    acc_cnt_d = m_cnt;
                    acc_x_d   = m_x;
                    acc_y_d   = m_y;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SYNC;
            acc_cnt_q <= '0;
            acc_x_q   <= X1;
            acc_y_q   <= Y1;
            miss_q    <= '0;
            tx_q      <= X1;
            ty_q      <= Y1;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            miss_q    <= miss_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
        end
    end

    assign T_x       = tx_q;
    assign T_y       = ty_q;
    assign box_valid = valid_q;
    assign pix_count = cnt_q;
    assign update    = upd_q;

endmodule

// File: tb/tb_fish_bbox_tracker.sv
// Scoreboard bench for fish_bbox_tracker: a behavioural model queues each expected commit,
// and a monitor pops and compares it when the update pulse appears.
module tb_fish_bbox_tracker;

    logic        clk = 1'b0;
    logic        reset, en, mask, frame_end;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [10:0] T_x;
    logic [9:0]  T_y;
    logic        box_valid, update;
    logic [15:0] pix_count;

    fish_bbox_tracker dut (
        .clk(clk), .reset(reset), .en(en), .pix_x(pix_x), .pix_y(pix_y),
        .mask(mask), .frame_end(frame_end), .T_x(T_x), .T_y(T_y),
        .box_valid(box_valid), .pix_count(pix_count), .update(update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] tx;
        logic [9:0]  ty;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_push = 0;
    int   n_upd = 0;

    // Reference model state
    bit          m_sync;
    int          m_cnt, m_miss;
    logic [10:0] m_x, m_tx;
    logic [9:0]  m_y, m_ty;
    bit          m_valid;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    endtask

    task automatic model_reset();
        m_sync = 1; m_cnt = 0; m_miss = 0;
        m_x = 11'd181; m_y = 10'd121;
        m_tx = 11'd181; m_ty = 10'd121; m_valid = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input int x, input int y, input bit m, input bit fe);
        exp_t ex;
        int cs;
        if (r) begin
            model_reset();
        end else if (m_sync) begin
            if (fe) begin
                m_sync = 0; m_cnt = 0; m_x = 11'd181; m_y = 10'd121;
            end
        end else begin
            if (e && m && x >= 181 && x <= 331 && y >= 121 && y <= 220) begin
                m_cnt++;
                if (x > int'(m_x)) m_x = 11'(x);
                if (y > int'(m_y)) m_y = 10'(y);
            end
            if (fe) begin
                cs = (m_cnt > 65535) ? 65535 : m_cnt;
                if (cs >= 16) begin
                    m_tx = m_x; m_ty = m_y; m_valid = 1; m_miss = 0;
                end else if (m_miss + 1 < 3) begin
                    m_miss++;
                end else begin
                    m_tx = 11'd181; m_ty = 10'd121; m_valid = 0; m_miss = 3;
                end
                ex.tx = m_tx; ex.ty = m_ty; ex.valid = m_valid; ex.cnt = 16'(cs);
                sb.push_back(ex);
                n_push++;
                m_cnt = 0; m_x = 11'd181; m_y = 10'd121;
            end
        end
    endtask

    // Drive one cycle; returns 1 time unit after the sampling edge
    task automatic drive(input bit r, input bit e, input int x, input int y, input bit m, input bit fe);
        reset = r; en = e; pix_x = 11'(x); pix_y = 10'(y); mask = m; frame_end = fe;
        model_step(r, e, x, y, m, fe);
        @(posedge clk);
        #1;
    endtask

    task automatic hits(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) drive(0, 1, x, y, 1, 0);
    endtask

    task automatic fend();
        drive(0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (update) begin
            if (sb.size() == 0) begin
                check("unexpected_update", 32'(update), 32'd0);
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                n_upd++;
                check("T_x", 32'(T_x), 32'(ex.tx));
                check("T_y", 32'(T_y), 32'(ex.ty));
                check("box_valid", 32'(box_valid), 32'(ex.valid));
                check("pix_count", 32'(pix_count), 32'(ex.cnt));
            end
        end
    end

    initial begin
        model_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_tx", 32'(T_x), 32'd181);
        check("rst_ty", 32'(T_y), 32'd121);
        check("rst_valid", 32'(box_valid), 32'd0);
        check("rst_cnt", 32'(pix_count), 32'd0);
        check("rst_upd", 32'(update), 32'd0);

        // Partial frame discarded in SYNC
        hits(5, 250, 150);
        fend();
        check("sync_no_upd", 32'(update), 32'd0);

        // 20 hits spanning x=200..250, y=130..180
        for (int i = 0; i < 20; i++) drive(0, 1, 200 + (i * 50) / 19, 130 + (i * 50) / 19, 1, 0);
        fend();
        check("t1_tx", 32'(T_x), 32'd250);
        check("t1_ty", 32'(T_y), 32'd180);
        check("t1_valid", 32'(box_valid), 32'd1);
        check("t1_cnt", 32'(pix_count), 32'd20);
        check("t1_upd", 32'(update), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        check("t1_upd_pulse", 32'(update), 32'd0);

        // Three misses of 15 hits: hold twice, drop on the third
        for (int f = 0; f < 3; f++) begin
            hits(15, 300, 200);
            fend();
            if (f < 2) check("miss_hold_tx", 32'(T_x), 32'd250);
        end
        check("drop_tx", 32'(T_x), 32'd181);
        check("drop_ty", 32'(T_y), 32'd121);
        check("drop_valid", 32'(box_valid), 32'd0);

        // ROI edges: outside pixels excluded, inclusive corner counted
        drive(0, 1, 180, 150, 1, 0);
        drive(0, 1, 332, 150, 1, 0);
        drive(0, 1, 200, 120, 1, 0);
        drive(0, 1, 200, 221, 1, 0);
        hits(16, 181, 121);
        fend();
        check("edge_tx", 32'(T_x), 32'd181);
        check("edge_cnt", 32'(pix_count), 32'd16);
        check("edge_valid", 32'(box_valid), 32'd1);

        // Hit on the frame_end cycle belongs to the closing frame
        hits(15, 200, 150);
        drive(0, 1, 320, 210, 1, 1);
        check("fe_hit_tx", 32'(T_x), 32'd320);
        check("fe_hit_ty", 32'(T_y), 32'd210);
        check("fe_hit_cnt", 32'(pix_count), 32'd16);

        // Masked pixels with en=0 are ignored
        for (int i = 0; i < 20; i++) drive(0, 0, 250, 150, 1, 0);
        fend();
        check("en0_cnt", 32'(pix_count), 32'd0);

        // Back-to-back frame_end: empty frames count as misses
        fend();
        fend();
        check("b2b_valid", 32'(box_valid), 32'd0);

        // Fresh detection, then reset mid-frame
        hits(16, 200, 140);
        fend();
        hits(10, 300, 200);
        drive(1, 1, 300, 200, 1, 0);
        check("mid_rst_tx", 32'(T_x), 32'd181);
        check("mid_rst_valid", 32'(box_valid), 32'd0);
        check("mid_rst_upd", 32'(update), 32'd0);
        hits(20, 300, 200);
        fend();
        check("mid_rst_sync_upd", 32'(update), 32'd0);
        hits(16, 190, 130);
        fend();
        check("post_rst_tx", 32'(T_x), 32'd190);

        // Random frames against the model
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 400; i++)
                drive(0, $urandom_range(0, 3) != 0, $urandom_range(170, 340),
                      $urandom_range(110, 230), 1'($urandom_range(0, 1)), 0);
            fend();
        end

        // Count saturation
        hits(70000, 250, 200);
        fend();
        check("sat_cnt", 32'(pix_count), 32'd65535);
        check("sat_valid", 32'(box_valid), 32'd1);

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("upd_count", 32'(n_upd), 32'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fish_bbox_tracker.md
Name: fish_bbox_tracker

Overview:
Upstream stage of the green box overlay. Consumes the per-pixel detection mask with its pixel coordinates and accumulates, over one video frame, the extent of detected pixels inside a fixed region of interest (ROI). At each frame end it commits the box corner T_x/T_y that the overlay stage draws from (X1,Y1). It also commits a pixel count and a valid flag, with miss-frame persistence so the box does not flicker.

Parameters:
X1, 11'd181, ROI left edge (inclusive); also the box origin used by the overlay
X2, 11'd331, ROI right edge (inclusive)
Y1, 10'd121, ROI top edge (inclusive)
Y2, 10'd220, ROI bottom edge (inclusive)
MIN_PIX, 16'd16, minimum in-ROI mask pixels per frame for a detection
MISS_LIMIT, 4'd3, consecutive missed frames before the box is dropped

Ports:
clk  input  1  pixel clock; only clock
reset  input  1  synchronous, active-high reset
en  input  1  pixel valid; pix_x, pix_y and mask are sampled only when en=1
pix_x  input  11  current pixel column
pix_y  input  10  current pixel row
mask  input  1  1 = pixel classified as fish
frame_end  input  1  single-cycle pulse marking the last cycle of a frame
T_x  output  11  committed box right edge
T_y  output  10  committed box bottom edge
box_valid  output  1  1 = committed box holds a live detection
pix_count  output  16  committed in-ROI mask pixel count of the last frame
update  output  1  one-cycle pulse on the cycle after each commit

Behaviour:
- All logic is on posedge clk. reset is synchronous and active-high; it has priority over every other input.
- Reset values: T_x=X1, T_y=Y1, box_valid=0, pix_count=0, update=0. Internal state: state=SYNC, acc_cnt=0, acc_x=X1, acc_y=Y1, miss_cnt=0.
- State SYNC: discards the partial frame after reset and ignores pixels. On frame_end, go to RUN with the accumulators cleared and no commit (update stays 0).
- State RUN:
  - Hit = en & mask & (X1<=pix_x<=X2) & (Y1<=pix_y<=Y2). All compares are unsigned and inclusive.
  - On a hit: acc_cnt increments, saturating at 16'hFFFF. acc_x <= max(acc_x, pix_x). acc_y <= max(acc_y, pix_y).
  - Pixels with en=0 are ignored regardless of mask and coordinates.
- Commit occurs on a frame_end cycle in RUN.
  - A hit in the same cycle as frame_end belongs to the closing frame. The commit uses the accumulator values with that hit merged in.
  - Detection (merged count >= MIN_PIX): T_x <= merged acc_x, T_y <= merged acc_y, box_valid <= 1, miss_cnt <= 0.
  - Miss, with miss_cnt+1 < MISS_LIMIT: T_x/T_y hold, box_valid holds, miss_cnt increments.
  - Miss, with miss_cnt+1 >= MISS_LIMIT: T_x <= X1, T_y <= Y1, box_valid <= 0, miss_cnt saturates at MISS_LIMIT.
  - pix_count <= merged count on every commit.
  - update=1 for exactly the cycle after the commit edge.
  - Accumulators reset to 0/X1/Y1 on the same edge, so pixels in the next cycle belong to the new frame.
- Latency: outputs change on the clock edge that samples frame_end and are stable for the whole following frame. Outputs never change mid-frame.
- Outputs always satisfy T_x>=X1 and T_y>=Y1, so the overlay never sees an inverted box.
- Back-to-back frame_end (consecutive cycles): each is a separate commit of an empty frame; each counts as a miss when MIN_PIX>0.
- Reset asserted mid-frame: the next cycle shows reset values; the tracker re-enters SYNC and discards the frame in progress.
- en=0 on a frame_end cycle: the commit still occurs (frame_end is not qualified by en).

Test Plan:
- Reset, then one frame_end, then a frame with 20 hits spanning x=200..250, y=130..180, then frame_end -> next cycle T_x=250, T_y=180, box_valid=1, pix_count=20, update=1 for one cycle.
- 15 hits at (300,200) then frame_end -> miss: T_x/T_y/box_valid unchanged, pix_count=15. After 3 consecutive such frames -> T_x=181, T_y=121, box_valid=0.
- Mask pixels at x=180, x=332, y=120, y=221 plus 16 hits at (181,121) -> T_x=181, T_y=121, pix_count=16; the edges are inclusive and the outside pixels are excluded.
- A 16th hit at (320,210) presented with en=1 in the same cycle as frame_end -> the hit is counted, giving T_x=320, T_y=210, pix_count=16.
- A frame of mask pixels with en=0 -> pix_count=0. Reset asserted mid-frame -> reset values next cycle; the first frame_end after reset produces no update pulse.
- 70000 hits in one frame -> pix_count=65535 (saturated), box_valid=1.
